mux_read_arbiter: RTL



---
 rtl/mux_read_arbiter_pkg.sv | 23 ++
 rtl/mux_read_arbiter_if.sv | 38 +++
 rtl/mux_read_arbiter_rr_pick.sv | 42 ++++
 rtl/mux_read_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/mux_read_arbiter_pkg.sv
// Shared definitions for the mux read arbiter slice.
//   - Default parameter values (requester count, word width, select width)
//   - rr_width(): width of a round-robin pointer / requester index
//   - state_t: arbiter FSM states
package mux_arb_pkg;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 6;

  // Index width for n requesters; a 1-bit index even for n == 1.
  function automatic int rr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RR_W = rr_width(DEF_NREQ);

  typedef enum logic {
    IDLE = 1'b0,
    SEL  = 1'b1
  } state_t;

endpackage

// File: rtl/mux_read_arbiter_if.sv
// Bundle between the requesters / shared 64:1 mux and the arbiter.
//   req_valid  : per-requester pending read
//   req_addr   : requester i address in [i*ADDR_W +: ADDR_W]
//   req_ready  : one-hot accept from the arbiter
//   mux_sel    : registered select to the shared mux
//   mux_data   : combinational word from the shared mux
//   rsp_valid  : one-hot single-cycle response pulse
//   rsp_data   : captured word
//   busy       : arbiter in SEL
// Modport slave is the arbiter side; master is the requester/mux side.
interface mux_read_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_ready;
  logic [ADDR_W-1:0]      mux_sel;
  logic [DATA_W-1:0]      mux_data;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic                   busy;

  modport master (
    output req_valid, req_addr, mux_data,
    input  req_ready, mux_sel, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_addr, mux_data,
    output req_ready, mux_sel, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/mux_read_arbiter_rr_pick.sv
// Combinational rotate-priority picker.
//   i_req : request vector
//   i_ptr : highest-priority position (must be < NREQ)
//   o_gnt : one-hot grant (zero when no request)
//   o_idx : index of the granted requester
//   o_any : at least one request present
module rr_pick #(
  parameter int NREQ = 4,
  parameter int RR_W = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [RR_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [RR_W-1:0] o_idx,
  output logic            o_any
);

  localparam int unsigned N = NREQ;

  int unsigned     w_pos;
  logic [NREQ-1:0] w_rot;

  // Scan offsets from farthest to nearest so the position closest to
  // i_ptr (offset 0) is written last and therefore wins.
  always_comb begin
    w_pos = '0;
    w_rot = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int unsigned k = N; k > 0; k--) begin
      w_pos = 32'(i_ptr) + k - 1;
      if (w_pos >= N) w_pos = w_pos - N;
      w_rot = i_req >> w_pos;
      if (w_rot[0]) begin
        o_idx = RR_W'(w_pos);
        o_any = 1'b1;
      end
    end
    o_gnt = o_any ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/mux_read_arbiter.sv
// Round-robin arbiter sharing one 64:1 read mux between NREQ requesters.
// One address accepted per handshake in IDLE; the select is registered so
// the mux sees it stable for the whole SEL cycle; the mux word is captured
// at the end of SEL and returned with a one-hot rsp_valid pulse.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mux_read_arbiter_if.slave (request, mux and response signals)
module mux_read_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic               clk,
  input logic               rst,
  mux_read_arbiter_if.slave bus
);

  localparam int PTR_W = rr_width(NREQ);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_gnt;
  logic [ADDR_W-1:0] r_mux_sel;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;

  logic [NREQ-1:0]   w_gnt;
  logic [PTR_W-1:0]  w_idx;
  logic              w_any;
  logic [NREQ-1:0]   w_ready;
  logic              w_hs;
  logic [ADDR_W-1:0] w_addr;
  logic [PTR_W-1:0]  w_ptr_nxt;

  rr_pick #(
    .NREQ (NREQ),
    .RR_W (PTR_W)
  ) u_pick (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_addr    = ADDR_W'(bus.req_addr >> (int'(w_idx) * ADDR_W));
  assign w_ptr_nxt = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // The grant is offered only to a requester that is already valid, so
  // any grant in IDLE outside reset is a completed handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_hs        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst) begin
          w_ready = w_gnt;
          w_hs    = w_any;
        end
        if (w_hs) w_state_nxt = SEL;
      end
      SEL: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_mux_sel   <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (w_hs) begin
        r_mux_sel <= w_addr;
        r_gnt     <= w_idx;
        r_ptr     <= w_ptr_nxt;
      end
      if (r_state == SEL) begin
        r_rsp_data  <= bus.mux_data;
        r_rsp_valid <= NREQ'(1) << r_gnt;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.mux_sel   = r_mux_sel;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = (r_state == SEL);

endmodule
